w5300_tx_engine: RTL and testbench



---
 rtl/w5300_pkg.sv | 55 +++++
 rtl/w5300_poll_timer.sv | 33 +++
 rtl/w5300_tx_engine.sv | 235 +++++++++++++++++++++++
 tb/tb_w5300_tx_engine.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/w5300_pkg.sv
`default_nettype none
// ============================================================================
// Module   : w5300_pkg
// Purpose  : W5300 register map, command/flag constants and shared types.
// Revision : 1.1 - socket TX sequencer additions
// ============================================================================
package w5300_pkg;

    localparam logic       c_rd = 1'b0;
    localparam logic       c_wr = 1'b1;

    localparam logic [9:0] c_sn_base          = 10'h200;
    localparam logic [9:0] c_sn_cr_off        = 10'h002;
    localparam logic [9:0] c_sn_ir_off        = 10'h006;
    localparam logic [9:0] c_sn_tx_wrsr0_off  = 10'h020;
    localparam logic [9:0] c_sn_tx_wrsr2_off  = 10'h022;
    localparam logic [9:0] c_sn_tx_fsr0_off   = 10'h024;
    localparam logic [9:0] c_sn_tx_fsr2_off   = 10'h026;
    localparam logic [9:0] c_sn_tx_fifor_off  = 10'h02E;

    localparam logic [15:0] c_sn_cr_send      = 16'h0020;
    localparam logic [15:0] c_sn_ir_sendok    = 16'h0010;
    localparam logic [15:0] c_sn_ir_timeout   = 16'h0008;

    // Parked bus word: a read of an unused register address
    localparam logic [10:0] c_idle_addr       = {c_rd, 10'h3fe};

    typedef enum logic [1:0] {
        TX_ERR_NONE       = 2'b00,
        TX_ERR_FSR        = 2'b01,
        TX_ERR_IR_TIMEOUT = 2'b10,
        TX_ERR_SENDOK     = 2'b11
    } tx_err_e;

    typedef enum logic [3:0] {
        S_IDLE    = 4'd0,
        S_LOAD    = 4'd1,
        S_RD_FSR  = 4'd2,
        S_CHK     = 4'd3,
        S_WR_FIFO = 4'd4,
        S_WR_WRSR = 4'd5,
        S_WR_CR   = 4'd6,
        S_POLL_IR = 4'd7,
        S_CLR_IR  = 4'd8,
        S_NEXT    = 4'd9,
        S_DONE    = 4'd10,
        S_ERR     = 4'd11
    } tx_state_e;

    function automatic logic [9:0] get_socket_n_reg(input logic [2:0] n, input logic [9:0] off);
        return c_sn_base + {1'b0, n, 6'd0} + off;
    endfunction

endpackage
`default_nettype wire

// File: rtl/w5300_poll_timer.sv
`default_nettype none
// ============================================================================
// Module   : w5300_poll_timer
// Purpose  : Saturating cycle counter flagging when a poll wait exceeds LIMIT.
// Revision : 1.0 - initial release
// ============================================================================
module w5300_poll_timer #(
    parameter int               CNT_W = 20,
    parameter logic [CNT_W-1:0] LIMIT = 20'd1000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    logic [CNT_W-1:0] r_count;

    assign expired = (r_count >= LIMIT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (clear) begin
            r_count <= '0;
        end else if (enable && !expired) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/w5300_tx_engine.sv
`default_nettype none
// ============================================================================
// Module   : w5300_tx_engine
// Purpose  : W5300 socket transmit sequencer: chunked FIFO writes, SEND, confirm.
// Revision : 2.0 - chunking, bounded polls, optional SENDOK confirmation
// ============================================================================
module w5300_tx_engine
    import w5300_pkg::*;
#(
    parameter logic [2:0]  N               = 3'd0,
    parameter int          BUF_AW          = 16,
    parameter logic [16:0] MAX_CHUNK_BYTES = 17'd8192,
    parameter logic [19:0] POLL_LIMIT      = 20'd1000000,
    parameter logic        WAIT_SENDOK     = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              tx_start,
    input  logic [16:0]       tx_bytes,
    output logic              tx_busy,
    output logic              tx_done,
    output logic              tx_err,
    output logic [1:0]        tx_err_code,
    output logic [BUF_AW-1:0] buf_addr,
    input  logic [15:0]       buf_data,
    output logic [10:0]       addr,
    output logic [15:0]       wr_data,
    input  logic [15:0]       rd_data,
    input  logic              op_state
);

    localparam logic [9:0]  c_reg_cr    = get_socket_n_reg(N, c_sn_cr_off);
    localparam logic [9:0]  c_reg_ir    = get_socket_n_reg(N, c_sn_ir_off);
    localparam logic [9:0]  c_reg_wrsr0 = get_socket_n_reg(N, c_sn_tx_wrsr0_off);
    localparam logic [9:0]  c_reg_wrsr2 = get_socket_n_reg(N, c_sn_tx_wrsr2_off);
    localparam logic [9:0]  c_reg_fsr0  = get_socket_n_reg(N, c_sn_tx_fsr0_off);
    localparam logic [9:0]  c_reg_fsr2  = get_socket_n_reg(N, c_sn_tx_fsr2_off);
    localparam logic [9:0]  c_reg_fifor = get_socket_n_reg(N, c_sn_tx_fifor_off);
    localparam logic [17:0] c_max_chunk = {1'b0, MAX_CHUNK_BYTES};

    tx_state_e         r_state;
    tx_state_e         w_next;
    tx_err_e           r_err_code;
    logic              r_sub;
    logic [17:0]       r_remaining;
    logic [17:0]       r_chunk;
    logic [17:0]       r_words;
    logic [17:0]       r_count;
    logic [16:0]       r_free;
    logic [BUF_AW-1:0] r_buf_addr;
    logic [17:0]       w_chunk;
    logic              w_timer_clr;
    logic              w_timer_en;
    logic              w_expired;

    assign w_chunk     = (r_remaining > c_max_chunk) ? c_max_chunk : r_remaining;
    assign tx_busy     = (r_state != S_IDLE);
    assign tx_done     = (r_state == S_DONE);
    assign tx_err      = (r_state == S_ERR);
    assign tx_err_code = r_err_code;
    assign buf_addr    = r_buf_addr;

    w5300_poll_timer #(
        .CNT_W (20),
        .LIMIT (POLL_LIMIT)
    ) u_poll_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (w_timer_clr),
        .enable  (w_timer_en),
        .expired (w_expired)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Bus word is a pure function of state and sub-counters, so it stays put until op_state
    always_comb begin
        w_next      = r_state;
        addr        = c_idle_addr;
        wr_data     = 16'h0000;
        w_timer_clr = 1'b0;
        w_timer_en  = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (tx_start) begin
                    w_next = (tx_bytes == 17'd0) ? S_DONE : S_LOAD;
                end
            end
            S_LOAD: begin
                w_timer_clr = 1'b1;
                w_next      = S_RD_FSR;
            end
            S_RD_FSR: begin
                w_timer_en = 1'b1;
                addr       = {c_rd, r_sub ? c_reg_fsr2 : c_reg_fsr0};
                if (op_state && r_sub) begin
                    w_next = S_CHK;
                end
            end
            S_CHK: begin
                w_timer_en = 1'b1;
                if ({1'b0, r_free} >= r_chunk) begin
                    w_next = S_WR_FIFO;
                end else if (w_expired) begin
                    w_next = S_ERR;
                end else begin
                    w_next = S_RD_FSR;
                end
            end
            S_WR_FIFO: begin
                if (r_count == r_words) begin
                    w_next = S_WR_WRSR;
                end else begin
                    addr    = {c_wr, c_reg_fifor};
                    wr_data = buf_data;
                end
            end
            S_WR_WRSR: begin
                addr    = {c_wr, r_sub ? c_reg_wrsr2 : c_reg_wrsr0};
                wr_data = r_sub ? r_chunk[15:0] : {15'd0, r_chunk[16]};
                if (op_state && r_sub) begin
                    w_next = S_WR_CR;
                end
            end
            S_WR_CR: begin
                w_timer_clr = 1'b1;
                addr        = {c_wr, c_reg_cr};
                wr_data     = c_sn_cr_send;
                if (op_state) begin
                    w_next = WAIT_SENDOK ? S_POLL_IR : S_NEXT;
                end
            end
            S_POLL_IR: begin
                w_timer_en = 1'b1;
                addr       = {c_rd, c_reg_ir};
                if (op_state) begin
                    if ((rd_data & c_sn_ir_timeout) != 16'h0000) begin
                        w_next = S_ERR;
                    end else if ((rd_data & c_sn_ir_sendok) != 16'h0000) begin
                        w_next = S_CLR_IR;
                    end else if (w_expired) begin
                        w_next = S_ERR;
                    end
                end
            end
            S_CLR_IR: begin
                addr    = {c_wr, c_reg_ir};
                wr_data = c_sn_ir_sendok;
                if (op_state) begin
                    w_next = S_NEXT;
                end
            end
            S_NEXT: begin
                w_next = (r_remaining == r_chunk) ? S_DONE : S_LOAD;
            end
            S_DONE:  w_next = S_IDLE;
            S_ERR:   w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err_code  <= TX_ERR_NONE;
            r_sub       <= 1'b0;
            r_remaining <= '0;
            r_chunk     <= '0;
            r_words     <= '0;
            r_count     <= '0;
            r_free      <= '0;
            r_buf_addr  <= '0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (tx_start) begin
                        r_remaining <= {1'b0, tx_bytes};
                        r_buf_addr  <= '0;
                        r_err_code  <= TX_ERR_NONE;
                    end
                end
                S_LOAD: begin
                    r_chunk <= w_chunk;
                    r_words <= (w_chunk + 18'd1) >> 1;
                    r_sub   <= 1'b0;
                end
                S_RD_FSR: begin
                    if (op_state) begin
                        if (r_sub) begin
                            r_free[15:0] <= rd_data;
                        end else begin
                            r_free[16] <= rd_data[0];
                        end
                        r_sub <= ~r_sub;
                    end
                end
                S_CHK: begin
                    r_count <= '0;
                    r_sub   <= 1'b0;
                    if (w_next == S_ERR) begin
                        r_err_code <= TX_ERR_FSR;
                    end
                end
                S_WR_FIFO: begin
                    if (op_state && (r_count != r_words)) begin
                        r_buf_addr <= r_buf_addr + BUF_AW'(1);
                        r_count    <= r_count + 18'd1;
                    end
                end
                S_WR_WRSR: begin
                    if (op_state) begin
                        r_sub <= ~r_sub;
                    end
                end
                S_POLL_IR: begin
                    if (w_next == S_ERR) begin
                        r_err_code <= ((rd_data & c_sn_ir_timeout) != 16'h0000) ?
                                      TX_ERR_IR_TIMEOUT : TX_ERR_SENDOK;
                    end
                end
                S_NEXT: begin
                    r_remaining <= r_remaining - r_chunk;
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_w5300_tx_engine.sv
`default_nettype none
// ============================================================================
// Module   : tb_w5300_tx_engine
// Purpose  : Directed bench for w5300_tx_engine with a W5300 bus responder.
// Revision : 1.0 - initial release
// ============================================================================
module tb_w5300_tx_engine;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sel = 1'b0;
    logic        start_a = 1'b0;
    logic        start_b = 1'b0;
    logic [16:0] tx_bytes = 17'd0;
    logic        op_tgl = 1'b0;
    logic        op_a, op_b;
    logic [15:0] rd_data;

    logic        busy_a, done_a, err_a, busy_b, done_b, err_b;
    logic [1:0]  code_a, code_b;
    logic [15:0] baddr_a, baddr_b, bdata_a, bdata_b, wdata_a, wdata_b;
    logic [10:0] addr_a, addr_b;

    logic        busy, done, err;
    logic [1:0]  code;
    logic [15:0] baddr, wdata;
    logic [10:0] addr;

    logic [16:0] fsr_big = 17'h02000;
    logic [16:0] fsr_small = 17'd0;
    logic [16:0] fsr_cur;
    int          fsr_small_n = 0;
    int          fsr_pairs = 0;
    logic [15:0] ir_val = 16'h0000;
    int          ir_zero_n = 0;
    int          ir_reads = 0;

    logic [10:0] log_addr [0:63];
    logic [15:0] log_data [0:63];
    int          nlog = 0;
    int          fifo_cnt = 0;
    int          fifo_bad = 0;
    int          done_cnt = 0;
    int          err_cnt = 0;
    int          tests = 0;
    int          fails = 0;

    always #5 clk = ~clk;

    w5300_tx_engine #(
        .N (3'd0), .BUF_AW (16), .MAX_CHUNK_BYTES (17'd8192),
        .POLL_LIMIT (20'd64), .WAIT_SENDOK (1'b0)
    ) dut_a (
        .clk (clk), .rst_n (rst_n), .tx_start (start_a), .tx_bytes (tx_bytes),
        .tx_busy (busy_a), .tx_done (done_a), .tx_err (err_a), .tx_err_code (code_a),
        .buf_addr (baddr_a), .buf_data (bdata_a), .addr (addr_a), .wr_data (wdata_a),
        .rd_data (rd_data), .op_state (op_a)
    );

    w5300_tx_engine #(
        .N (3'd0), .BUF_AW (16), .MAX_CHUNK_BYTES (17'd8192),
        .POLL_LIMIT (20'd64), .WAIT_SENDOK (1'b1)
    ) dut_b (
        .clk (clk), .rst_n (rst_n), .tx_start (start_b), .tx_bytes (tx_bytes),
        .tx_busy (busy_b), .tx_done (done_b), .tx_err (err_b), .tx_err_code (code_b),
        .buf_addr (baddr_b), .buf_data (bdata_b), .addr (addr_b), .wr_data (wdata_b),
        .rd_data (rd_data), .op_state (op_b)
    );

    assign bdata_a = baddr_a ^ 16'hC33C;
    assign bdata_b = baddr_b ^ 16'hC33C;
    assign op_a    = op_tgl & ~sel;
    assign op_b    = op_tgl & sel;
    assign busy    = sel ? busy_b  : busy_a;
    assign done    = sel ? done_b  : done_a;
    assign err     = sel ? err_b   : err_a;
    assign code    = sel ? code_b  : code_a;
    assign baddr   = sel ? baddr_b : baddr_a;
    assign wdata   = sel ? wdata_b : wdata_a;
    assign addr    = sel ? addr_b  : addr_a;

    // Register file model for socket 0: FSR at 0x224/0x226, Sn_IR at 0x206
    always_comb begin
        fsr_cur = (fsr_pairs <= fsr_small_n) ? fsr_small : fsr_big;
        rd_data = 16'h0000;
        case (addr)
            11'h224: rd_data = {15'd0, fsr_cur[16]};
            11'h226: rd_data = fsr_cur[15:0];
            11'h206: rd_data = (ir_reads <= ir_zero_n) ? 16'h0000 : ir_val;
            default: ;
        endcase
    end

    // op_state is raised every second cycle; an access is recorded when op goes high
    always @(negedge clk) begin
        if (!rst_n) begin
            op_tgl = 1'b0;
        end else begin
            if (!op_tgl && addr != 11'h3FE) begin
                if (addr == 11'h62E) begin
                    if (wdata !== (fifo_cnt[15:0] ^ 16'hC33C) || baddr !== fifo_cnt[15:0])
                        fifo_bad++;
                    fifo_cnt++;
                end else begin
                    if (nlog < 64) begin
                        log_addr[nlog] = addr;
                        log_data[nlog] = wdata;
                    end
                    nlog++;
                    if (addr == 11'h224) fsr_pairs++;
                    if (addr == 11'h206) ir_reads++;
                end
            end
            op_tgl = ~op_tgl;
        end
        if (done) done_cnt++;
        if (err) err_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic start(input logic s, input logic [16:0] b);
        @(negedge clk);
        nlog = 0; fifo_cnt = 0; fifo_bad = 0; fsr_pairs = 0; ir_reads = 0;
        done_cnt = 0; err_cnt = 0;
        sel = s;
        tx_bytes = b;
        if (s) start_b = 1'b1; else start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        start_b = 1'b0;
    endtask

    task automatic wait_end(input int budget);
        int n;
        n = 0;
        while (done_cnt == 0 && err_cnt == 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        repeat (6) @(negedge clk);
    endtask

    function automatic int count_addr(input logic [10:0] a);
        int c;
        c = 0;
        for (int i = 0; i < 64; i++)
            if (i < nlog && log_addr[i] == a) c++;
        return c;
    endfunction

    initial begin
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_code", code, 0);
        check("rst_baddr", baddr, 0);
        check("rst_addr", addr, 11'h3FE);
        check("rst_wdata", wdata, 0);
        rst_n = 1'b1;

        // 6 bytes, single chunk, no SENDOK wait
        start(1'b0, 17'd6);
        check("t1_busy", busy, 1);
        wait_end(400);
        check("t1_done", done_cnt, 1);
        check("t1_err", err_cnt, 0);
        check("t1_fifo", fifo_cnt, 3);
        check("t1_fifo_seq", fifo_bad, 0);
        check("t1_nlog", nlog, 5);
        check("t1_fsr0", {log_addr[0], log_data[0]}, {11'h224, 16'h0000});
        check("t1_fsr2", {log_addr[1], log_data[1]}, {11'h226, 16'h0000});
        check("t1_wrsr0", {log_addr[2], log_data[2]}, {11'h620, 16'h0000});
        check("t1_wrsr2", {log_addr[3], log_data[3]}, {11'h622, 16'h0006});
        check("t1_cr", {log_addr[4], log_data[4]}, {11'h602, 16'h0020});
        check("t1_idle", busy, 0);

        // 20001 bytes -> 8192 + 8192 + 3617
        start(1'b0, 17'd20001);
        wait_end(60000);
        check("t2_done", done_cnt, 1);
        check("t2_fifo", fifo_cnt, 10001);
        check("t2_fifo_seq", fifo_bad, 0);
        check("t2_baddr", baddr, 16'd10001);
        check("t2_nlog", nlog, 15);
        check("t2_wrsr2_c0", {log_addr[3], log_data[3]}, {11'h622, 16'h2000});
        check("t2_wrsr2_c1", {log_addr[8], log_data[8]}, {11'h622, 16'h2000});
        check("t2_wrsr0_c2", {log_addr[12], log_data[12]}, {11'h620, 16'h0000});
        check("t2_wrsr2_c2", {log_addr[13], log_data[13]}, {11'h622, 16'h0E21});
        check("t2_cr_cnt", count_addr(11'h602), 3);

        // FSR too small three times, then enough; a start while busy is ignored
        fsr_small = 17'd4; fsr_small_n = 3; fsr_big = 17'h00100;
        start(1'b0, 17'd100);
        repeat (3) @(negedge clk);
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        wait_end(2000);
        repeat (20) @(negedge clk);
        check("t3_done", done_cnt, 1);
        check("t3_fsr_pairs", count_addr(11'h224), 4);
        check("t3_fsr2_cnt", count_addr(11'h226), 4);
        check("t3_fifo", fifo_cnt, 50);
        check("t3_fifo_seq", fifo_bad, 0);
        check("t3_no_requeue", busy, 0);

        // FSR stuck at zero -> FSR timeout
        fsr_small_n = 0; fsr_big = 17'd0;
        start(1'b0, 17'd100);
        wait_end(1000);
        check("t4_err", err_cnt, 1);
        check("t4_done", done_cnt, 0);
        check("t4_code", code, 2'b01);
        check("t4_fifo", fifo_cnt, 0);
        check("t4_no_cr", count_addr(11'h602), 0);

        // zero-length transfer, also clears the held error code
        start(1'b0, 17'd0);
        check("t5_done_next", done, 1);
        check("t5_code_clr", code, 2'b00);
        repeat (3) @(negedge clk);
        check("t5_done_cnt", done_cnt, 1);
        check("t5_no_bus", nlog + fifo_cnt, 0);

        // SENDOK confirmation after two empty Sn_IR reads
        fsr_big = 17'h02000; ir_zero_n = 2; ir_val = 16'h0010;
        start(1'b1, 17'd6);
        wait_end(400);
        check("t6_done", done_cnt, 1);
        check("t6_err", err_cnt, 0);
        check("t6_nlog", nlog, 9);
        check("t6_ir_reads", count_addr(11'h206), 3);
        check("t6_ir_clr", {log_addr[8], log_data[8]}, {11'h606, 16'h0010});

        // TIMEOUT and SENDOK together: TIMEOUT wins
        ir_zero_n = 0; ir_val = 16'h0018;
        start(1'b1, 17'd6);
        wait_end(400);
        check("t7_err", err_cnt, 1);
        check("t7_done", done_cnt, 0);
        check("t7_code", code, 2'b10);
        check("t7_nlog", nlog, 6);
        check("t7_no_clr", count_addr(11'h606), 0);

        // Sn_IR never reports anything -> SENDOK poll timeout
        ir_zero_n = 1000; ir_val = 16'h0000;
        start(1'b1, 17'd6);
        wait_end(1000);
        check("t8_err", err_cnt, 1);
        check("t8_code", code, 2'b11);
        check("t8_no_clr", count_addr(11'h606), 0);

        // Reset in the middle of the FIFO burst
        start(1'b0, 17'd100);
        for (int n = 0; n < 2000 && fifo_cnt < 5; n++) @(negedge clk);
        check("t9_reached_fifo", fifo_cnt, 5);
        rst_n = 1'b0;
        #1;
        check("t9_busy", busy, 0);
        check("t9_baddr", baddr, 0);
        check("t9_addr", addr, 11'h3FE);
        check("t9_wdata", wdata, 0);
        check("t9_done", done, 0);
        check("t9_err", err, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        start(1'b0, 17'd100);
        wait_end(2000);
        check("t9_restart_fsr", log_addr[0], 11'h224);
        check("t9_restart_fifo", fifo_cnt, 50);
        check("t9_restart_seq", fifo_bad, 0);
        check("t9_restart_done", done_cnt, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
